filter_scan_ctrl: RTL and testbench
===================================

# filter_scan_ctrl

Frame-scan sequencer for the 3x3 neighbourhood colour filters (averager, edge and sharpen variants sharing the 108-bit window bus). For every pixel of a stored RGB444 frame it:
- fetches the nine neighbours from the source frame RAM, with edge coordinates clamped;
- packs them onto the filter's `color_data` bus and holds it stable for the filter's pipeline latency;
- writes the filter's 12-bit result to the destination frame RAM.

It sits between the frame buffers and whichever filter instance is selected.

## Interface
- `WIDTH`, 160, frame width in pixels
- `HEIGHT`, 120, frame height in pixels
- `ADDR_W`, 15, RAM address width; must satisfy `WIDTH*HEIGHT <= 2**ADDR_W`
- `LAT`, 4, filter latency in clocks from `color_data` change to valid `filter_rgb_out` (minimum 1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: begin one frame pass; sampled only in IDLE
- `abort` in 1: synchronous; terminates the pass without further writes
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse after the last pixel's write
- `rd_en` out 1: source RAM read strobe
- `rd_addr` out ADDR_W: source RAM address
- `rd_data` in 12: source pixel, valid exactly one clock after `rd_en`
- `color_data` out 108: window to filter
- `filter_rgb_out` in 12: filter result
- `wr_en` out 1: destination RAM write strobe
- `wr_addr` out ADDR_W: destination address
- `wr_data` out 12: destination pixel

## Operation
- Packing of `color_data` (12 bits each):
  - original [107:96]
  - left [95:84]
  - right [83:72]
  - up [71:60]
  - down [59:48]
  - upleft [47:36]
  - upright [35:24]
  - downleft [23:12]
  - downright [11:0]
- Tap order `k` = 0..8 follows the same sequence: original, left, right, up, down, upleft, upright, downleft, downright.
- Tap offsets (dx, dy):
  - (0,0), (-1,0), (+1,0), (0,-1), (0,+1)
  - (-1,-1), (+1,-1), (-1,+1), (+1,+1)
- Tap address: `clamp(y+dy,0,HEIGHT-1)*WIDTH + clamp(x+dx,0,WIDTH-1)`. Use the unsigned ADDR_W result with no wrap between rows.
- Scan order: raster, x fastest, starting at (0,0).
- FSM states:
  - **IDLE**: `start`=1 → FETCH with x=y=0, k=0.
  - **FETCH**: `rd_en`=1, `rd_addr`=tap k, k increments each cycle. `rd_data` returned for tap k-1 is stored into staging slot k-1. After k=8 → CAPTURE.
  - **CAPTURE**: `rd_en`=0. Store tap 8, then copy the full staging register to `color_data` at the end of this cycle → WAIT with counter=0.
  - **WAIT**: count LAT cycles → WRITE.
  - **WRITE**: `wr_en`=1, `wr_addr`=y*WIDTH+x, `wr_data`=`filter_rgb_out` (combinational pass-through). Then advance x; at x=WIDTH-1 set x=0 and advance y. Last pixel (WIDTH-1, HEIGHT-1) → DONE; otherwise → FETCH with k=0.
  - **DONE**: `done`=1 for one cycle, `busy`=0 → IDLE.
- `color_data` changes only on the CAPTURE edge. It stays stable through WAIT, WRITE and the following FETCH.
- `start` while busy is ignored. `start` in DONE is ignored.
- `abort`=1 in any non-IDLE state: next state IDLE, `busy`=0, no `done`. A write already asserted in the current WRITE cycle completes; no further writes.
- `abort` and `start` together in IDLE: `abort` wins, start ignored.
- Reset:
  - all outputs 0, `color_data`=0, state IDLE, counters 0;
  - reset asserted mid-frame discards the pass with no further strobes;
  - after reset release, nothing happens until a new `start`.

## Timing
- Per pixel: 9 FETCH + 1 CAPTURE + LAT WAIT + 1 WRITE = LAT+11 clocks.
- Frame: `start` accepted at edge E0. `busy` rises after E0. First `rd_en` is in the cycle following E0.
- `done` is high in the cycle after the final WRITE.
- Total from the `start` edge to the `done` cycle: `WIDTH*HEIGHT*(LAT+11)+1` clocks.
- `rd_en` and `wr_en` are never high in the same cycle.
- The filter sees stable input for at least LAT+1 edges before its output is sampled.

## Test plan
1. WIDTH=4, HEIGHT=3, LAT=4, pulse `start` → pixel (0,0) `rd_addr` sequence 0,0,1,0,4,0,1,4,5; first `wr_addr`=0 on the 15th cycle after acceptance.
2. Same frame, corner pixel (3,2) → `rd_addr` sequence 11,10,11,7,11,6,7,10,11; `wr_addr`=11; `done` 181 cycles after the `start` edge; exactly 12 writes.
3. Averaging filter model, uniform source 0xABC → every `wr_data`=0xABC. Source where address n holds n → written values match a golden 3x3 clamped-mean model.
4. `abort` pulsed in WAIT of pixel 5 → no write for pixel 5, `busy`=0 next cycle, `done` never pulses. A new `start` restarts at addr 0.
5. `reset` low during FETCH of pixel 2 → all outputs 0 immediately (asynchronous). After release, no strobes until `start`.
6. `start` held high throughout, plus `start`+`abort` together in IDLE → second start is ignored while busy; the simultaneous pair is not accepted (stays IDLE).

Source files
------------

// File: rtl/filter_scan_ctrl.sv
// Frame-scan sequencer: gathers a clamped 3x3 RGB444 window for every pixel,
// presents it to a 3x3 filter, and stores the filter result in the destination frame.
module filter_scan_ctrl #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [107:0]      color_data,
  input  logic [11:0]       filter_rgb_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam int                CW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(LAT - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] x, y;
  logic [3:0]        k;
  logic [CW-1:0]     cnt;
  logic [11:0]       stage [0:7];

  logic [ADDR_W-1:0] xl, xr, yu, yd, col, row;

  // Clamped neighbour coordinates; tap k selects the (col,row) pair to read.
  always_comb begin
    xl  = (x == '0)     ? x : x - ONE_A;
    xr  = (x == X_LAST) ? x : x + ONE_A;
    yu  = (y == '0)     ? y : y - ONE_A;
    yd  = (y == Y_LAST) ? y : y + ONE_A;
    col = x;
    row = y;
    case (k)
      4'd0:    begin col = x;  row = y;  end
      4'd1:    begin col = xl; row = y;  end
      4'd2:    begin col = xr; row = y;  end
      4'd3:    begin col = x;  row = yu; end
      4'd4:    begin col = x;  row = yd; end
      4'd5:    begin col = xl; row = yu; end
      4'd6:    begin col = xr; row = yu; end
      4'd7:    begin col = xl; row = yd; end
      default: begin col = xr; row = yd; end
    endcase
  end

  // Read protocol: rd_data carries the word addressed by rd_en/rd_addr one clock
  // later, with no backpressure; writes are fire-and-forget on wr_en.
  assign fsm_state = state;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign rd_en     = (state == S_FETCH);
  assign wr_en     = (state == S_WRITE);
  assign rd_addr   = rd_en ? (row * W_A + col) : '0;
  assign wr_addr   = wr_en ? (y * W_A + x) : '0;
  assign wr_data   = wr_en ? filter_rgb_out : 12'h000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      k          <= '0;
      cnt        <= '0;
      color_data <= '0;
      for (int i = 0; i < 8; i++) stage[i] <= 12'h000;
    end else if (abort) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            x     <= '0;
            y     <= '0;
            k     <= '0;
          end
        end
        S_FETCH: begin
          // The word arriving now belongs to the previous tap.
          if (k != 4'd0) stage[k[2:0] - 3'd1] <= rd_data;
          if (k == 4'd8) state <= S_CAPTURE;
          else           k     <= k + 4'd1;
        end
        S_CAPTURE: begin
          color_data <= {stage[0], stage[1], stage[2], stage[3],
                         stage[4], stage[5], stage[6], stage[7], rd_data};
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) state <= S_WRITE;
          else                 cnt   <= cnt + CW'(1);
        end
        S_WRITE: begin
          k <= '0;
          if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
              y     <= '0;
              state <= S_DONE;
            end else begin
              y     <= y + ONE_A;
              state <= S_FETCH;
            end
          end else begin
            x     <= x + ONE_A;
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Bench for filter_scan_ctrl on a 4x3 frame with an averaging filter model of latency 4.
module tb_filter_scan_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 15;
  localparam int LAT  = 4;
  localparam int NPIX = W * H;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd3;

  typedef struct {
    int          cyc;
    logic [63:0] outs;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [11:0]   rd_data;
  logic [107:0]  color_data;
  logic [11:0]   filter_rgb_out, wr_data;
  logic [2:0]    fsm_state;

  logic [11:0]   src_mem [0:NPIX-1];
  logic [11:0]   fpipe [0:LAT-1];
  logic [26:0]   exp_q[$];
  vec_t          vecs[$];
  int            seq0 [0:8] = '{0, 0, 1, 0, 4, 0, 1, 4, 5};
  int            seq11[0:8] = '{11, 10, 11, 7, 11, 6, 7, 10, 11};
  int            n_cmp = 0;
  int            n_err = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;

  // Clock and reset
  always #5 clk = ~clk;

  filter_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .color_data(color_data), .filter_rgb_out(filter_rgb_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fsm_state(fsm_state)
  );

  // Source RAM with one-clock read latency
  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr[3:0]];

  function automatic logic [11:0] avg9(input logic [107:0] win);
    int sr, sg, sb;
    logic [11:0] p;
    sr = 0; sg = 0; sb = 0;
    for (int i = 0; i < 9; i++) begin
      p = win[i*12 +: 12];
      sr += int'(p[11:8]); sg += int'(p[7:4]); sb += int'(p[3:0]);
    end
    return {4'(sr / 9), 4'(sg / 9), 4'(sb / 9)};
  endfunction

  // Averaging filter with LAT clocks of latency
  always @(posedge clk) begin
    fpipe[0] <= avg9(color_data);
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign filter_rgb_out = fpipe[LAT-1];

  function automatic logic [11:0] golden(input int px, input int py);
    int sr, sg, sb, xx, yy;
    logic [11:0] p;
    sr = 0; sg = 0; sb = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = px + dx; yy = py + dy;
        if (xx < 0) xx = 0;
        if (xx > W - 1) xx = W - 1;
        if (yy < 0) yy = 0;
        if (yy > H - 1) yy = H - 1;
        p = src_mem[yy * W + xx];
        sr += int'(p[11:8]); sg += int'(p[7:4]); sb += int'(p[3:0]);
      end
    end
    return {4'(sr / 9), 4'(sg / 9), 4'(sb / 9)};
  endfunction

  function automatic logic [63:0] pk(input logic b, input logic d, input logic re,
                                     input logic [14:0] ra, input logic we,
                                     input logic [14:0] wa);
    return 64'({b, d, re, ra, we, wa});
  endfunction

  function automatic logic [63:0] cur();
    return pk(busy, done, rd_en, rd_addr, wr_en, wr_addr);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Scoreboard and strobe monitor
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      if (rd_en && wr_en) begin
        n_err++;
        $display("FAIL rd_wr_overlap rd_en=%b wr_en=%b required not both high", rd_en, wr_en);
      end
    end
    if (wr_en) begin
      wr_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected got addr=%0d data=%h required no write", wr_addr, wr_data);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_err++;
          $display("FAIL wr_scoreboard got addr=%0d data=%h required addr=%0d data=%h",
                   wr_addr, wr_data, e[26:12], e[11:0]);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_golden(input int npx);
    for (int p = 0; p < npx; p++) exp_q.push_back({15'(p), golden(p % W, p / W)});
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < NPIX; n++) src_mem[n] = 12'(n);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout got no done after %0d cycles required done", budget);
    end
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog got simulation still running required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int w0, d0, cyc;

    // Expected output vectors for one frame, by cycle after the start edge
    for (int i = 0; i < 9; i++) vecs.push_back('{i + 1, pk(1, 0, 1, 15'(seq0[i]), 0, 0), "px0_rd"});
    vecs.push_back('{10, pk(1, 0, 0, 0, 0, 0), "px0_capture"});
    vecs.push_back('{14, pk(1, 0, 0, 0, 0, 0), "px0_wait"});
    vecs.push_back('{15, pk(1, 0, 0, 0, 1, 0), "px0_write"});
    vecs.push_back('{16, pk(1, 0, 1, 1, 0, 0), "px1_first_rd"});
    for (int i = 0; i < 9; i++) vecs.push_back('{166 + i, pk(1, 0, 1, 15'(seq11[i]), 0, 0), "px11_rd"});
    vecs.push_back('{180, pk(1, 0, 0, 0, 1, 11), "px11_write"});
    vecs.push_back('{181, pk(0, 1, 0, 0, 0, 0), "frame_done"});
    vecs.push_back('{182, pk(0, 0, 0, 0, 0, 0), "after_done"});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", cur(), 64'd0);
    check("rst_color", 64'(|color_data), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(S_IDLE));
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", cur(), 64'd0);

    // Uniform frame: address sequences, write timing, done timing
    for (int n = 0; n < NPIX; n++) src_mem[n] = 12'hABC;
    for (int p = 0; p < NPIX; p++) exp_q.push_back({15'(p), 12'hABC});
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    for (int c = 1; c <= 182; c++) begin
      if (c > 1) @(negedge clk);
      foreach (vecs[j]) if (vecs[j].cyc == c) check(vecs[j].name, cur(), vecs[j].outs);
    end
    check("uni_writes", 64'(wr_cnt - w0), 64'd12);
    check("uni_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("uni_queue", 64'(exp_q.size()), 64'd0);

    // Ramp frame against the clamped-mean model
    fill_ramp();
    push_golden(NPIX);
    w0 = wr_cnt;
    pulse_start();
    wait_done(400, cyc);
    check("ramp_done_cycle", 64'(cyc), 64'd180);
    @(negedge clk);
    check("ramp_writes", 64'(wr_cnt - w0), 64'd12);
    check("ramp_queue", 64'(exp_q.size()), 64'd0);

    // Abort during WAIT of pixel 5
    push_golden(5);
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    repeat (85) @(negedge clk);
    check("abort_in_wait", 64'(fsm_state), 64'(S_WAIT));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'({busy, fsm_state}), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_writes", 64'(wr_cnt - w0), 64'd5);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);

    // Restart, then asynchronous reset during FETCH of pixel 2
    push_golden(2);
    w0 = wr_cnt;
    pulse_start();
    check("restart_rd", cur(), pk(1, 0, 1, 0, 0, 0));
    repeat (32) @(negedge clk);
    check("rst_mid_fetch", 64'(fsm_state), 64'(S_FETCH));
    #2 reset = 1'b0;
    #1;
    check("rst_async_outs", cur(), 64'd0);
    check("rst_async_color", 64'(|color_data), 64'd0);
    check("rst_async_wdata", 64'(wr_data), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({busy, done, rd_en, wr_en}), 64'd0);
    end
    check("rst_writes", 64'(wr_cnt - w0), 64'd2);
    check("rst_queue", 64'(exp_q.size()), 64'd0);

    // start held high while busy; start during DONE ignored
    push_golden(NPIX);
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk) start = 1'b1;
    repeat (100) @(negedge clk);
    check("held_start_busy", 64'({busy, fsm_state == S_IDLE}), 64'b10);
    start = 1'b0;
    repeat (81) @(negedge clk);
    check("held_start_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 64'({busy, done, rd_en, fsm_state}), 64'd0);
    @(negedge clk);
    check("start_in_done_quiet", 64'({busy, rd_en}), 64'd0);
    check("held_writes", 64'(wr_cnt - w0), 64'd12);
    check("held_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("held_queue", 64'(exp_q.size()), 64'd0);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'({busy, rd_en, fsm_state}), 64'd0);
    repeat (2) @(negedge clk);
    check("start_abort_quiet", 64'({busy, rd_en, wr_en, fsm_state}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
